// File: rtl/drive_arbiter.sv
// Drive command arbiter: selects one of N_SRC command sources through a guarded
// switch, resolves conflicting moves, applies obstacle interlocks and generates barrier pulses.
module drive_arbiter #(
  parameter int N_SRC        = 4,
  parameter int SEL_W        = 2,
  parameter int GUARD_CYCLES = 8,
  parameter int PULSE_CYCLES = 2,
  parameter int INTERLOCK_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SEL_W-1:0]     mode_sel,
  input  logic [6*N_SRC-1:0]   src_cmd,
  input  logic [3:0]           detector,
  output logic                 move_forward,
  output logic                 move_backward,
  output logic                 turn_left,
  output logic                 turn_right,
  output logic                 place_barrier,
  output logic                 destroy_barrier,
  output logic [SEL_W-1:0]     active_src,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_RUN   = 2'b01,
    ST_GUARD = 2'b10
  } state_t;

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES);
  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES);
  localparam logic       IL         = (INTERLOCK_EN != 0);

  state_t           r_state;
  logic [SEL_W-1:0] r_active;
  logic [SEL_W-1:0] r_target;
  logic [7:0]       r_gcnt;
  logic [3:0]       r_pcnt;
  logic [1:0]       r_hist;
  logic             r_fwd, r_back, r_left, r_right, r_place, r_destroy;

  logic [5:0]       w_src [N_SRC];
  logic [5:0]       w_cmd;
  logic [5:0]       w_tcmd;
  logic [SEL_W-1:0] w_sel;
  logic             w_fwd, w_back, w_left, w_right, w_rise_p, w_rise_d;

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    assign w_src[k] = src_cmd[6*k +: 6];
  end

  // Out-of-range selections collapse to the OFF source.
  always_comb begin
    w_sel  = (int'(mode_sel) < N_SRC) ? mode_sel : '0;
    w_cmd  = '0;
    w_tcmd = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (int'(r_active) == k) w_cmd  = w_src[k];
      if (int'(r_target) == k) w_tcmd = w_src[k];
    end
  end

  always_comb begin
    w_fwd    = w_cmd[5] & ~w_cmd[4] & ~(IL & detector[3]);
    w_back   = w_cmd[4] & ~w_cmd[5] & ~(IL & detector[2]);
    w_left   = w_cmd[3] & ~w_cmd[2] & ~(IL & detector[1]);
    w_right  = w_cmd[2] & ~w_cmd[3] & ~(IL & detector[0]);
    w_rise_p = w_cmd[1] & ~r_hist[1];
    w_rise_d = w_cmd[0] & ~r_hist[0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_OFF;
      r_active  <= '0;
      r_target  <= '0;
      r_gcnt    <= '0;
      r_pcnt    <= '0;
      r_hist    <= '0;
      r_fwd     <= 1'b0;
      r_back    <= 1'b0;
      r_left    <= 1'b0;
      r_right   <= 1'b0;
      r_place   <= 1'b0;
      r_destroy <= 1'b0;
    end else begin
      case (r_state)
        ST_OFF, ST_RUN: begin
          if (w_sel != r_active) begin
            r_state   <= ST_GUARD;
            r_target  <= w_sel;
            r_active  <= '0;
            r_gcnt    <= GUARD_LOAD;
            r_pcnt    <= '0;
            r_fwd     <= 1'b0;
            r_back    <= 1'b0;
            r_left    <= 1'b0;
            r_right   <= 1'b0;
            r_place   <= 1'b0;
            r_destroy <= 1'b0;
          end else if (r_state == ST_RUN) begin
            r_fwd   <= w_fwd;
            r_back  <= w_back;
            r_left  <= w_left;
            r_right <= w_right;
            r_hist  <= w_cmd[1:0];
            // A running pulse swallows any new edges; simultaneous edges cancel.
            if (r_pcnt != 4'd0) begin
              if (r_pcnt == 4'd1) begin
                r_place   <= 1'b0;
                r_destroy <= 1'b0;
                r_pcnt    <= '0;
              end else begin
                r_pcnt <= r_pcnt - 4'd1;
              end
            end else if (w_rise_p ^ w_rise_d) begin
              r_place   <= w_rise_p;
              r_destroy <= w_rise_d;
              r_pcnt    <= PULSE_LOAD;
            end
          end
        end
        ST_GUARD: begin
          if (w_sel != r_target) begin
            r_target <= w_sel;
            r_gcnt   <= GUARD_LOAD;
          end else if (r_gcnt <= 8'd1) begin
            r_gcnt   <= '0;
            r_active <= r_target;
            r_hist   <= w_tcmd[1:0];
            r_state  <= (r_target != '0) ? ST_RUN : ST_OFF;
          end else begin
            r_gcnt <= r_gcnt - 8'd1;
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign move_forward    = r_fwd;
  assign move_backward   = r_back;
  assign turn_left       = r_left;
  assign turn_right      = r_right;
  assign place_barrier   = r_place;
  assign destroy_barrier = r_destroy;
  assign active_src      = r_active;
  assign state           = r_state;

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter: interlocked, non-interlocked and wide-select
// instances share stimulus; table vectors cover RUN behaviour, sequences cover switching.
module tb_drive_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  modeSel;
  logic [2:0]  wideSel;
  logic [23:0] srcCmd;
  logic [3:0]  detector;

  logic       mfIl, mbIl, tlIl, trIl, pbIl, dbIl;
  logic [1:0] actIl, stIl;
  logic       mfNo, mbNo, tlNo, trNo, pbNo, dbNo;
  logic [1:0] actNo, stNo;
  logic       mfW, mbW, tlW, trW, pbW, dbW;
  logic [2:0] actW;
  logic [1:0] stW;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  drive_arbiter u_il (
    .clk(clk), .reset(reset), .mode_sel(modeSel), .src_cmd(srcCmd), .detector(detector),
    .move_forward(mfIl), .move_backward(mbIl), .turn_left(tlIl), .turn_right(trIl),
    .place_barrier(pbIl), .destroy_barrier(dbIl), .active_src(actIl), .state(stIl)
  );

  drive_arbiter #(.INTERLOCK_EN(0)) u_noil (
    .clk(clk), .reset(reset), .mode_sel(modeSel), .src_cmd(srcCmd), .detector(detector),
    .move_forward(mfNo), .move_backward(mbNo), .turn_left(tlNo), .turn_right(trNo),
    .place_barrier(pbNo), .destroy_barrier(dbNo), .active_src(actNo), .state(stNo)
  );

  drive_arbiter #(.SEL_W(3)) u_wide (
    .clk(clk), .reset(reset), .mode_sel(wideSel), .src_cmd(srcCmd), .detector(detector),
    .move_forward(mfW), .move_backward(mbW), .turn_left(tlW), .turn_right(trW),
    .place_barrier(pbW), .destroy_barrier(dbW), .active_src(actW), .state(stW)
  );

  wire [9:0] obsIl   = {stIl, actIl, mfIl, mbIl, tlIl, trIl, pbIl, dbIl};
  wire [5:0] outsNo  = {mfNo, mbNo, tlNo, trNo, pbNo, dbNo};
  wire [9:0] obsWide = {stW, actW[1:0], mfW, mbW, tlW, trW, pbW, dbW};

  localparam logic [9:0] OFF_IDLE   = 10'b00_00_000000;
  localparam logic [9:0] GUARD_IDLE = 10'b10_00_000000;

  typedef struct {
    logic [5:0] cmd;
    logic [3:0] det;
    logic [5:0] expIl;
    logic [5:0] expNoIl;
  } vec_t;

  vec_t vecs [29];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source 2 occupies bits [17:12]; all other sources stay quiet.
  task automatic applyStimulus(input logic [1:0] sel, input logic [5:0] cmd2, input logic [3:0] det);
    modeSel  = sel;
    srcCmd   = {6'b0, cmd2, 12'b0};
    detector = det;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual[9:0], expected[9:0]);
    end
  endtask

  initial begin
    vecs[0]  = '{6'b100000, 4'b0000, 6'b100000, 6'b100000};
    vecs[1]  = '{6'b100000, 4'b1000, 6'b000000, 6'b100000};
    vecs[2]  = '{6'b100000, 4'b0000, 6'b100000, 6'b100000};
    vecs[3]  = '{6'b111000, 4'b0000, 6'b001000, 6'b001000};
    vecs[4]  = '{6'b011100, 4'b0000, 6'b010000, 6'b010000};
    vecs[5]  = '{6'b000100, 4'b0001, 6'b000000, 6'b000100};
    vecs[6]  = '{6'b010000, 4'b0100, 6'b000000, 6'b010000};
    vecs[7]  = '{6'b001000, 4'b0010, 6'b000000, 6'b001000};
    vecs[8]  = '{6'b111100, 4'b0000, 6'b000000, 6'b000000};
    vecs[9]  = '{6'b000010, 4'b0000, 6'b000010, 6'b000010};
    vecs[10] = '{6'b000010, 4'b0000, 6'b000010, 6'b000010};
    for (int i = 11; i <= 18; i++) vecs[i] = '{6'b000010, 4'b0000, 6'b000000, 6'b000000};
    vecs[19] = '{6'b000000, 4'b0000, 6'b000000, 6'b000000};
    vecs[20] = '{6'b000011, 4'b0000, 6'b000000, 6'b000000};
    vecs[21] = '{6'b000000, 4'b0000, 6'b000000, 6'b000000};
    vecs[22] = '{6'b000001, 4'b0000, 6'b000001, 6'b000001};
    vecs[23] = '{6'b000011, 4'b0000, 6'b000001, 6'b000001};
    vecs[24] = '{6'b000011, 4'b0000, 6'b000000, 6'b000000};
    vecs[25] = '{6'b000000, 4'b0000, 6'b000000, 6'b000000};
    vecs[26] = '{6'b100010, 4'b1000, 6'b000010, 6'b100010};
    vecs[27] = '{6'b100010, 4'b0000, 6'b100010, 6'b100010};
    vecs[28] = '{6'b100000, 4'b0000, 6'b100000, 6'b100000};

    reset    = 1'b0;
    modeSel  = 2'd0;
    wideSel  = 3'd0;
    srcCmd   = '0;
    detector = '0;
    tick();
    tick();
    checkOutput("reset_state", 32'(obsIl), 32'(OFF_IDLE));
    checkOutput("reset_wide", 32'(obsWide), 32'(OFF_IDLE));

    // Power-up switch to source 2: eight guard cycles, then one-cycle command latency.
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'd2, 6'b100000, 4'b0000);
      checkOutput($sformatf("first_guard_%0d", i), 32'(obsIl), 32'(GUARD_IDLE));
    end
    applyStimulus(2'd2, 6'b100000, 4'b0000);
    checkOutput("enter_run", 32'(obsIl), 32'(10'b01_10_000000));
    applyStimulus(2'd2, 6'b100000, 4'b0000);
    checkOutput("first_fwd", 32'(obsIl), 32'(10'b01_10_100000));

    for (int i = 0; i < 29; i++) begin
      applyStimulus(2'd2, vecs[i].cmd, vecs[i].det);
      checkOutput($sformatf("vec%0d_il", i), 32'(obsIl), 32'({4'b01_10, vecs[i].expIl}));
      checkOutput($sformatf("vec%0d_noil", i), 32'(outsNo), 32'(vecs[i].expNoIl));
    end

    // Pulse cut by a mode change, then a 2->3->2 bounce inside one guard.
    applyStimulus(2'd2, 6'b000000, 4'b0000);
    checkOutput("pre_pulse_idle", 32'(obsIl), 32'(10'b01_10_000000));
    applyStimulus(2'd2, 6'b000010, 4'b0000);
    checkOutput("pulse_start", 32'(obsIl), 32'(10'b01_10_000010));
    applyStimulus(2'd3, 6'b000010, 4'b0000);
    checkOutput("pulse_cut", 32'(obsIl), 32'(GUARD_IDLE));
    applyStimulus(2'd3, 6'b000010, 4'b0000);
    checkOutput("bounce_guard", 32'(obsIl), 32'(GUARD_IDLE));
    applyStimulus(2'd2, 6'b000010, 4'b0000);
    checkOutput("bounce_back", 32'(obsIl), 32'(GUARD_IDLE));
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(2'd2, 6'b000010, 4'b0000);
      checkOutput($sformatf("restart_guard_%0d", i), 32'(obsIl),
                  32'((i < 8) ? GUARD_IDLE : 10'b01_10_000000));
    end
    applyStimulus(2'd2, 6'b000010, 4'b0000);
    checkOutput("held_place_quiet", 32'(obsIl), 32'(10'b01_10_000000));
    applyStimulus(2'd2, 6'b000000, 4'b0000);
    applyStimulus(2'd2, 6'b000010, 4'b0000);
    checkOutput("place_after_entry", 32'(obsIl), 32'(10'b01_10_000010));

    // Reset during guard, then wide instance ignores an out-of-range select.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(2'd1, 6'b000000, 4'b0000);
      checkOutput($sformatf("pre_reset_guard_%0d", i), 32'(obsIl), 32'(GUARD_IDLE));
    end
    reset = 1'b0;
    applyStimulus(2'd1, 6'b000000, 4'b0000);
    checkOutput("reset_mid_guard", 32'(obsIl), 32'(OFF_IDLE));
    applyStimulus(2'd1, 6'b000000, 4'b0000);
    checkOutput("reset_held", 32'(obsIl), 32'(OFF_IDLE));
    reset   = 1'b1;
    wideSel = 3'd5;
    applyStimulus(2'd1, 6'b000000, 4'b0000);
    checkOutput("release_guard", 32'(obsIl), 32'(GUARD_IDLE));
    checkOutput("wide_sel5_off", 32'(obsWide), 32'(OFF_IDLE));
    for (int i = 1; i <= 8; i++) applyStimulus(2'd1, 6'b000000, 4'b0000);
    checkOutput("run_src1", 32'(obsIl), 32'(10'b01_01_000000));
    checkOutput("wide_still_off", 32'(obsWide), 32'(OFF_IDLE));
    wideSel = 3'd1;
    applyStimulus(2'd1, 6'b000000, 4'b0000);
    checkOutput("wide_sel1_guard", 32'(obsWide), 32'(GUARD_IDLE));

    // Switching to OFF still passes through a full guard.
    applyStimulus(2'd0, 6'b000000, 4'b0000);
    checkOutput("off_guard", 32'(obsIl), 32'(GUARD_IDLE));
    for (int i = 1; i <= 7; i++) applyStimulus(2'd0, 6'b000000, 4'b0000);
    checkOutput("off_guard_last", 32'(obsIl), 32'(GUARD_IDLE));
    applyStimulus(2'd0, 6'b000000, 4'b0000);
    checkOutput("off_reached", 32'(obsIl), 32'(OFF_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/drive_arbiter.md
DRIVE_ARBITER -- requirements
Module: drive_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, the number of command sources; source 0 is reserved as OFF and its commands are never driven.
REQ-002 SHALL have parameter SEL_W, default 2, the width of mode_sel and active_src, with 2^SEL_W >= N_SRC.
REQ-003 SHALL have parameter GUARD_CYCLES, default 8, the number of all-outputs-idle cycles forced on every source switch (range 1..255).
REQ-004 SHALL have parameter PULSE_CYCLES, default 2, the barrier output pulse length (range 1..15).
REQ-005 SHALL have parameter INTERLOCK_EN, default 1; when 1, moves into obstacles are suppressed.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the clk rising edge.
REQ-008 SHALL have port mode_sel, input, SEL_W bits: the requested source index.
REQ-009 SHALL have port src_cmd, input, 6*N_SRC bits: source k occupies bits [6k+5:6k] as {fwd, back, left, right, place, destroy}.
REQ-010 SHALL have port detector, input, 4 bits: {front, back, left, right}, where 1 means an obstacle.
REQ-011 SHALL have ports move_forward, move_backward, turn_left and turn_right, each output, 1 bit, registered.
REQ-012 SHALL have ports place_barrier and destroy_barrier, each output, 1 bit: registered pulses.
REQ-013 SHALL have port active_src, output, SEL_W bits: the source currently driving the outputs (0 = none).
REQ-014 SHALL have port state, output, 2 bits: 00 OFF, 01 RUN, 10 GUARD.

Function
REQ-015 SHALL treat a mode_sel value >= N_SRC as 0.
REQ-016 SHALL implement a three-state FSM with states OFF, RUN and GUARD.
REQ-017 SHALL transition from OFF or RUN to GUARD when the effective mode_sel differs from active_src; it SHALL latch target = mode_sel, set active_src = 0, and load the counter with GUARD_CYCLES.
REQ-018 SHALL decrement the counter by 1 per cycle in GUARD; at 0 it SHALL set active_src = target and go to RUN if target != 0, else to OFF.
REQ-019 SHALL, when mode_sel changes to a value other than target during GUARD, relatch target and reload the counter (the guard restarts).
REQ-020 SHALL hold all six command outputs at 0 in OFF and GUARD.
REQ-021 SHALL drive the outputs in RUN from source active_src with 1-cycle latency (src_cmd sampled at edge n appears after edge n).
REQ-022 SHALL, when fwd and back are both 1, output neither; when left and right are both 1, output neither.
REQ-023 SHALL, with INTERLOCK_EN = 1, force move_forward = 0 while detector[3] = 1, move_backward = 0 while detector[2] = 1, turn_left = 0 while detector[1] = 1, and turn_right = 0 while detector[0] = 1; the detector is sampled in the same cycle as the command.
REQ-024 SHALL start a PULSE_CYCLES-long pulse on place_barrier only on a 0->1 edge of the active source's place bit in RUN, and likewise for destroy and destroy_barrier.
REQ-025 SHALL initialise the edge-detect history to the current bits on entry to RUN, so a held bit does not fire.
REQ-026 SHALL ignore both edges when place and destroy rise in the same cycle.
REQ-027 SHALL ignore further edges while a pulse is active (no retrigger or extension).
REQ-028 SHALL immediately clear a running pulse and its counter on leaving RUN.
REQ-029 SHALL never assert place_barrier and destroy_barrier together.
REQ-030 SHALL never assert move_forward and move_backward together, nor turn_left and turn_right together.

Reset
REQ-031 SHALL, while reset = 0 at a clk edge, enter OFF and clear all outputs, active_src, target, the guard counter, the pulse counter and the edge history to 0.
REQ-032 SHALL, on reset asserted mid-GUARD or mid-pulse, abort the operation at that edge with no residual output.
REQ-033 SHALL, at the first edge with reset = 1 and mode_sel = k != 0, enter GUARD with target k.

Verification
REQ-034 SHALL be verified by: reset, then mode_sel = 2 with src 2 fwd = 1 -> state = GUARD for 8 cycles with all outputs 0, then RUN, active_src = 2, move_forward = 1 one cycle after each sample.
REQ-035 SHALL be verified by: in RUN on src 2, mode_sel 2->3->2 within 3 cycles -> a single GUARD whose counter restarts on each change; active_src = 2 exactly 8 cycles after the last change.
REQ-036 SHALL be verified by: in RUN with fwd = 1, detector = 4'b1000 -> move_forward = 0; detector -> 0 gives move_forward = 1 next cycle; with INTERLOCK_EN = 0 it stays 1.
REQ-037 SHALL be verified by: src fwd = back = 1 and left = 1 -> outputs {0, 0, 1, 0}.
REQ-038 SHALL be verified by: place held high for 10 cycles -> place_barrier high for exactly 2 cycles; place and destroy rising together -> no pulse; mode change mid-pulse -> pulse cut next edge.
REQ-039 SHALL be verified by: reset = 0 asserted on GUARD cycle 3 -> state = OFF and all outputs 0 at that edge; mode_sel = 5 with N_SRC = 4 -> treated as 0, state remains OFF.
